// File: rtl/alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// alu_seq_ctrl
//
// Command-side sequencer for a combinational N-bit ALU. A command (op, A, B)
// is accepted over a valid/ready handshake, presented to the ALU for exactly
// one cycle, and the ALU result and flags are captured and returned over a
// valid/ready response handshake. The last captured result is kept so that a
// chained command can use it as operand A (cmd_fwd_a).
//
// Optional feature macro: ALU_SEQ_STICKY_EN
//   defined   : sticky_carry / sticky_overflow accumulate captured flags,
//               sticky_clr clears them (a capture in the same cycle wins).
//   undefined : sticky outputs tied 0, sticky_clr ignored.
//
// Ports
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready       command handshake
//   cmd_op/cmd_a/cmd_b        command op and operands
//   cmd_fwd_a                 use last captured result as operand A
//   alu_en/alu_op/alu_a/alu_b ALU request port (alu_en high one cycle)
//   alu_result/alu_carry/alu_overflow/alu_zero  ALU response (combinational)
//   rsp_valid/rsp_ready       response handshake
//   rsp_op/rsp_result/rsp_carry/rsp_overflow/rsp_zero  captured response
//   op_count                  completed responses, wraps 255 -> 0
//   sticky_clr                clear sticky flags
//   sticky_carry/sticky_overflow  accumulated flags
// -----------------------------------------------------------------------------
module alu_seq_ctrl #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [2:0]   cmd_op,
  input  logic [N-1:0] cmd_a,
  input  logic [N-1:0] cmd_b,
  input  logic         cmd_fwd_a,
  output logic         alu_en,
  output logic [2:0]   alu_op,
  output logic [N-1:0] alu_a,
  output logic [N-1:0] alu_b,
  input  logic [N-1:0] alu_result,
  input  logic         alu_carry,
  input  logic         alu_overflow,
  input  logic         alu_zero,
  output logic         rsp_valid,
  input  logic         rsp_ready,
  output logic [2:0]   rsp_op,
  output logic [N-1:0] rsp_result,
  output logic         rsp_carry,
  output logic         rsp_overflow,
  output logic         rsp_zero,
  output logic [7:0]   op_count,
  input  logic         sticky_clr,
  output logic         sticky_carry,
  output logic         sticky_overflow
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } state_t;

  state_t       state, state_nxt;
  logic [N-1:0] prev_result;
  logic         accept, capture, complete;

  assign accept   = (state == IDLE)  && cmd_valid;
  assign capture  = (state == ISSUE);
  assign complete = (state == RESP)  && rsp_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: every output of this block gets a default before the case so no
  // path leaves a signal unassigned (which would infer a latch).
  always_comb begin
    state_nxt = state;
    cmd_ready = 1'b0;
    alu_en    = 1'b0;
    rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_nxt = ISSUE;
      end
      ISSUE: begin
        alu_en    = 1'b1;
        state_nxt = RESP;
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // The command registers drive the ALU port directly: they only change on
  // accept, so outside ISSUE the ALU inputs hold the last issued command.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_op <= '0;
      alu_a  <= '0;
      alu_b  <= '0;
    end else if (accept) begin
      alu_op <= cmd_op;
      alu_a  <= cmd_fwd_a ? prev_result : cmd_a;
      alu_b  <= cmd_b;
    end
  end

  // Response capture at the end of the ISSUE cycle; held until the next one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_op       <= '0;
      rsp_result   <= '0;
      rsp_carry    <= 1'b0;
      rsp_overflow <= 1'b0;
      rsp_zero     <= 1'b0;
      prev_result  <= '0;
    end else if (capture) begin
      rsp_op       <= alu_op;
      rsp_result   <= alu_result;
      rsp_carry    <= alu_carry;
      rsp_overflow <= alu_overflow;
      rsp_zero     <= alu_zero;
      prev_result  <= alu_result;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)           op_count <= '0;
    else if (complete) op_count <= op_count + 8'd1;
  end

`ifdef ALU_SEQ_STICKY_EN
  // A clear and a flag-setting capture on the same edge leave the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sticky_carry    <= 1'b0;
      sticky_overflow <= 1'b0;
    end else begin
      sticky_carry    <= (sticky_carry    & ~sticky_clr) | (capture & alu_carry);
      sticky_overflow <= (sticky_overflow & ~sticky_clr) | (capture & alu_overflow);
    end
  end
`else
  logic unused_sticky_clr;
  assign unused_sticky_clr = sticky_clr;
  assign sticky_carry      = 1'b0;
  assign sticky_overflow   = 1'b0;
`endif

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_ctrl
//
// Self-checking bench for alu_seq_ctrl (N=4). A behavioural stand-in for the
// team ALU is attached to the alu_* port. Expected responses come from a
// directed vector table and, for random traffic, from an integer-arithmetic
// reference of the ALU ops plus a small transaction-level model
// (previous result, completed count, sticky flags).
// -----------------------------------------------------------------------------
module tb_alu_seq_ctrl;

  localparam int N = 4;
  localparam int W = 1 << N;

  logic         clk, rst;
  logic         cmd_valid, cmd_ready, cmd_fwd_a;
  logic [2:0]   cmd_op;
  logic [N-1:0] cmd_a, cmd_b;
  logic         alu_en;
  logic [2:0]   alu_op;
  logic [N-1:0] alu_a, alu_b, alu_result;
  logic         alu_carry, alu_overflow, alu_zero;
  logic         rsp_valid, rsp_ready;
  logic [2:0]   rsp_op;
  logic [N-1:0] rsp_result;
  logic         rsp_carry, rsp_overflow, rsp_zero;
  logic [7:0]   op_count;
  logic         sticky_clr, sticky_carry, sticky_overflow;

  alu_seq_ctrl #(.N(N)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_fwd_a(cmd_fwd_a),
    .alu_en(alu_en), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .alu_overflow(alu_overflow), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_op(rsp_op),
    .rsp_result(rsp_result), .rsp_carry(rsp_carry),
    .rsp_overflow(rsp_overflow), .rsp_zero(rsp_zero),
    .op_count(op_count), .sticky_clr(sticky_clr),
    .sticky_carry(sticky_carry), .sticky_overflow(sticky_overflow)
  );

  // Stand-in for the team ALU (vector form); sub carry means "no borrow".
  logic [N:0] alu_wide;
  always_comb begin
    alu_wide     = '0;
    alu_overflow = 1'b0;
    case (alu_op)
      3'd0: begin
        alu_wide     = {1'b0, alu_a} + {1'b0, alu_b};
        alu_overflow = (alu_a[N-1] == alu_b[N-1]) && (alu_wide[N-1] != alu_a[N-1]);
      end
      3'd1: begin
        alu_wide     = {1'b0, alu_a} + {1'b0, ~alu_b} + (N+1)'(1);
        alu_overflow = (alu_a[N-1] != alu_b[N-1]) && (alu_wide[N-1] != alu_a[N-1]);
      end
      3'd2: alu_wide = {1'b0, ~alu_a};
      3'd3: alu_wide = {1'b0, alu_a & alu_b};
      3'd4: alu_wide = {1'b0, alu_a | alu_b};
      3'd5: alu_wide = {1'b0, alu_a ^ alu_b};
      3'd6: alu_wide = {{N{1'b0}}, ($signed(alu_a) < $signed(alu_b))};
      default: alu_wide = {{N{1'b0}}, (alu_a == alu_b)};
    endcase
    alu_result = alu_wide[N-1:0];
    alu_carry  = (alu_op == 3'd0 || alu_op == 3'd1) ? alu_wide[N] : 1'b0;
    alu_zero   = (alu_result == '0);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  int en_cnt = 0;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (alu_en) en_cnt <= en_cnt + 1;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int n_cmp = 0;
  int n_fail = 0;

  // Transaction-level model state.
  logic [N-1:0] m_prev;
  logic [7:0]   m_count;
  logic         m_sc, m_so;
  int           last_acc;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Integer-arithmetic reference of the ALU ops.
  function automatic void ref_alu(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                                  output logic [N-1:0] r, output logic c, output logic v, output logic z);
    int ua, ub, sa, sb, res;
    ua = int'(a);
    ub = int'(b);
    sa = (ua >= W / 2) ? ua - W : ua;
    sb = (ub >= W / 2) ? ub - W : ub;
    c  = 1'b0;
    v  = 1'b0;
    case (op)
      3'd0: begin res = ua + ub; c = (res >= W); v = (sa + sb >= W / 2) || (sa + sb < -(W / 2)); end
      3'd1: begin res = ua - ub; c = (ua >= ub); v = (sa - sb >= W / 2) || (sa - sb < -(W / 2)); end
      3'd2: res = W - 1 - ua;
      3'd3: res = ua & ub;
      3'd4: res = ua | ub;
      3'd5: res = ua ^ ub;
      3'd6: res = (sa < sb) ? 1 : 0;
      default: res = (ua == ub) ? 1 : 0;
    endcase
    res = ((res % W) + W) % W;
    r   = N'(res);
    z   = (res == 0);
  endfunction

  function automatic logic exp_sticky(input logic m);
`ifdef ALU_SEQ_STICKY_EN
    return m;
`else
    return 1'b0 & m;
`endif
  endfunction

  // One full command: offer, ISSUE, RESP (optionally stalled), back to IDLE.
  task automatic run_cmd(input logic [2:0] op, input logic [N-1:0] a, input logic [N-1:0] b,
                         input logic fwd, input logic [N-1:0] er, input logic ec,
                         input logic ev, input logic ez, input int stall,
                         input logic clr, input bit chk_gap);
    logic [N-1:0] ea;
    int t;
    ea = fwd ? m_prev : a;
    t = 0;
    while (!cmd_ready && t < 10) begin @(posedge clk); #1; t++; end
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_fwd_a = fwd;
    rsp_ready = (stall == 0);
    @(posedge clk); #1;
    if (chk_gap) check("cmd_spacing", cyc - last_acc, 3);
    last_acc  = cyc;
    cmd_valid = 1'b0; cmd_fwd_a = 1'b0; cmd_a = ~a;
    sticky_clr = clr;
    check("issue_alu_en", alu_en, 1);
    check("issue_alu_op", alu_op, op);
    check("issue_alu_a", alu_a, ea);
    check("issue_alu_b", alu_b, b);
    check("issue_cmd_ready", cmd_ready, 0);
    check("issue_rsp_valid", rsp_valid, 0);
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    m_prev = er;
    m_sc = (m_sc & ~clr) | ec;
    m_so = (m_so & ~clr) | ev;
    check("resp_alu_en", alu_en, 0);
    check("resp_rsp_valid", rsp_valid, 1);
    check("resp_op", rsp_op, op);
    check("resp_result", rsp_result, er);
    check("resp_carry", rsp_carry, ec);
    check("resp_overflow", rsp_overflow, ev);
    check("resp_zero", rsp_zero, ez);
    if (stall > 0) begin
      cmd_valid = 1'b1; cmd_op = ~op; cmd_a = ~ea; cmd_b = ~b;
    end
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_rsp_valid", rsp_valid, 1);
      check("stall_result", rsp_result, er);
      check("stall_op", rsp_op, op);
      check("stall_cmd_ready", cmd_ready, 0);
      check("stall_alu_en", alu_en, 0);
      if (i == stall - 1) begin cmd_valid = 1'b0; rsp_ready = 1'b1; end
    end
    @(posedge clk); #1;
    m_count = m_count + 8'd1;
    check("done_rsp_valid", rsp_valid, 0);
    check("done_op_count", op_count, m_count);
    check("done_alu_op_held", alu_op, op);
    check("done_alu_a_held", alu_a, ea);
    check("done_result_held", rsp_result, er);
    check("done_sticky_carry", sticky_carry, exp_sticky(m_sc));
    check("done_sticky_ovf", sticky_overflow, exp_sticky(m_so));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_alu_en", alu_en, 0);
    check("rst_op_count", op_count, 0);
    check("rst_alu_op", alu_op, 0);
    check("rst_alu_a", alu_a, 0);
    check("rst_rsp_result", rsp_result, 0);
    check("rst_sticky", {sticky_carry, sticky_overflow}, 0);
    cmd_valid = 1'b0; rsp_ready = 1'b1; sticky_clr = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    m_prev = '0; m_count = '0; m_sc = 1'b0; m_so = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_rsp_valid", rsp_valid, 0);
    check("post_rst_op_count", op_count, 0);
  endtask

  typedef struct {
    logic [2:0]   op;
    logic [N-1:0] a, b;
    logic         fwd;
    logic [N-1:0] res;
    logic         c, v, z;
  } vec_t;

  vec_t vecs[13];

  initial begin
    logic [2:0]   rop;
    logic [N-1:0] ra, rb, er, ea;
    logic         rf, ec, ev, ez, rclr;
    int           e0;

    //               op     a        b        fwd   res      c     v     z
    vecs[0]  = '{3'd0, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{3'd1, 4'b0011, 4'b0011, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{3'd7, 4'b1010, 4'b0000, 1'b1, 4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{3'd6, 4'b1000, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0};
    vecs[4]  = '{3'd2, 4'b0101, 4'b0011, 1'b0, 4'b1010, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{3'd3, 4'b1100, 4'b1010, 1'b0, 4'b1000, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'd4, 4'b1100, 4'b1010, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'd5, 4'b1111, 4'b1111, 1'b0, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[8]  = '{3'd0, 4'b1111, 4'b0001, 1'b0, 4'b0000, 1'b1, 1'b0, 1'b1};
    vecs[9]  = '{3'd1, 4'b0000, 4'b0001, 1'b0, 4'b1111, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'd1, 4'b1000, 4'b0001, 1'b0, 4'b0111, 1'b1, 1'b1, 1'b0};
    vecs[11] = '{3'd6, 4'b0000, 4'b1000, 1'b1, 4'b0000, 1'b0, 1'b0, 1'b1};
    vecs[12] = '{3'd0, 4'b1111, 4'b0101, 1'b1, 4'b0101, 1'b0, 1'b0, 1'b0};

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0;
    cmd_fwd_a = 1'b0; rsp_ready = 1'b1; sticky_clr = 1'b0; last_acc = 0;
    m_prev = '0; m_count = '0; m_sc = 1'b0; m_so = 1'b0;
    do_reset();

    // Directed vectors, including forwarding of the previous result.
    for (int i = 0; i < 13; i++)
      run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].fwd,
              vecs[i].res, vecs[i].c, vecs[i].v, vecs[i].z, 0, 1'b0, 1'b0);

    // Signed compare held in RESP for 5 cycles while another command is offered.
    run_cmd(3'd6, 4'b1000, 4'b0001, 1'b0, 4'b0001, 1'b0, 1'b0, 1'b0, 5, 1'b0, 1'b0);

    // Reset while stalled in RESP drops the command; prev_result restarts at 0.
    cmd_valid = 1'b1; cmd_op = 3'd0; cmd_a = 4'b0101; cmd_b = 4'b0001; rsp_ready = 1'b0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("pre_rst_rsp_valid", rsp_valid, 1);
    do_reset();
    run_cmd(3'd0, 4'b1001, 4'b0011, 1'b1, 4'b0011, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);

    // 256 back-to-back xor commands: 3-cycle spacing, count wraps to 0.
    do_reset();
    e0 = en_cnt;
    for (int i = 0; i < 256; i++) begin
      ra = N'($urandom); rb = N'($urandom);
      ref_alu(3'd5, ra, rb, er, ec, ev, ez);
      run_cmd(3'd5, ra, rb, 1'b0, er, ec, ev, ez, 0, 1'b0, i > 0);
    end
    check("op_count_wrap", op_count, 0);
    check("alu_en_cycles", en_cnt - e0, 256);

    // Sticky flags: overflow set, then a clear coinciding with a carry capture.
    do_reset();
    run_cmd(3'd0, 4'b0111, 4'b0001, 1'b0, 4'b1000, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0);
    run_cmd(3'd1, 4'b0011, 4'b0001, 1'b0, 4'b0010, 1'b1, 1'b0, 1'b0, 0, 1'b1, 1'b0);
    sticky_clr = 1'b1;
    @(posedge clk); #1;
    sticky_clr = 1'b0;
    m_sc = 1'b0; m_so = 1'b0;
    check("clr_sticky_carry", sticky_carry, 0);
    check("clr_sticky_ovf", sticky_overflow, 0);

    // Random traffic against the reference model.
    for (int i = 0; i < 150; i++) begin
      rop  = 3'($urandom_range(0, 7));
      ra   = N'($urandom);
      rb   = N'($urandom);
      rf   = ($urandom_range(0, 3) == 0);
      rclr = ($urandom_range(0, 5) == 0);
      ea   = rf ? m_prev : ra;
      ref_alu(rop, ea, rb, er, ec, ev, ez);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk); #1;
        check("gap_alu_en", alu_en, 0);
      end
      run_cmd(rop, ra, rb, rf, er, ec, ev, ez, $urandom_range(0, 3), rclr, 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
